// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential packed-BCD to unsigned binary converter. It uses the reverse
//   double-dabble algorithm and retires one bit per SHIFT cycle.
//
//   Optional build macro: BCD_DIGIT_CHECK_EN
//     defined   : an operand with any nibble > 9 is rejected when it is
//                 accepted. The FSM goes straight to DONE with bin=0, err=1.
//     undefined : no digit check. err is tied to 0. Invalid nibbles run the
//                 normal algorithm and give a deterministic but meaningless
//                 result.
//
//   Ports
//     clk   in   1         rising-edge clock
//     rst   in   1         synchronous, active-high reset
//     start in   1         conversion request, sampled only when idle
//     bcd   in   4*DIGITS  packed BCD operand, digit 0 in bits [3:0]
//     busy  out  1         high in SHIFT and DONE
//     done  out  1         one-cycle pulse; bin/err valid
//     bin   out  4*DIGITS  binary result, held until the next DONE
//     err   out  1         invalid-digit flag (only with BCD_DIGIT_CHECK_EN)
module bcd_to_binary #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bin,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     work;
  logic [W-1:0]     result;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     work_nxt;
  logic [W-1:0]     result_nxt;
  logic             last_shift;
  logic             bad_digit;

  // After the right shift, a nibble with its MSB set has received a bit worth
  // 8 from the digit above. In decimal that bit is worth only 5, so take 3 off.
  function automatic logic [W-1:0] fix_nibbles(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i+3]) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic err_q;

  assign bad_digit = has_bad_digit(bcd);
  assign err       = err_q;
`else
  assign bad_digit = 1'b0;
  assign err       = 1'b0;
`endif

  // Shift/correct step: compute the next {work, result} pair combinationally.
  always_comb begin
    result_nxt = {work[0], result[W-1:1]};
    work_nxt   = fix_nibbles({1'b0, work[W-1:1]});
  end

  assign last_shift = (count == LAST_SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = bad_digit ? DONE : SHIFT;
      end
      SHIFT: begin
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State and datapath registers, all advanced on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      result <= '0;
      count  <= '0;
      bin    <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= bcd;
            result <= '0;
            count  <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            if (bad_digit) begin
              bin   <= '0;
              err_q <= 1'b1;
            end
`endif
          end
        end
        SHIFT: begin
          work   <= work_nxt;
          result <= result_nxt;
          count  <= count + CNT_W'(1);
          if (last_shift) begin
            bin <= result_nxt;
`ifdef BCD_DIGIT_CHECK_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary
//   Testbench for bcd_to_binary with DIGITS=3. A cycle-level behavioural
//   model computes the decimal value of each accepted operand arithmetically.
//   It also tracks how long the converter must stay busy. Directed scenarios
//   and a randomized phase drive the DUT, with literal expectations in the
//   directed cases.
module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = 4 * DIGITS + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] bcd = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] bin;
  logic         err;

  bcd_to_binary #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  function automatic int dec_value(input logic [W-1:0] v);
    int acc;
    acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  function automatic bit has_bad(input logic [W-1:0] v);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction
`endif

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD_DIGIT_CHECK_EN
    if ($urandom_range(0, 3) == 0) begin
      int p;
      p = int'($urandom_range(0, DIGITS - 1));
      v[4*p +: 4] = 4'($urandom_range(10, 15));
    end
`endif
    return v;
  endfunction

  // Behavioural model: m_left is the number of cycles the converter must
  // still be busy. It is 0 when idle and 1 during the done cycle.
  int           m_left = 0;
  logic [W-1:0] m_pend_bin = '0;
  logic [W-1:0] m_bin = '0;
  logic         m_pend_err = 1'b0;
  logic         m_err = 1'b0;

  always @(posedge clk) begin
    bit bad;
    bad = 1'b0;
    if (rst) begin
      m_left = 0;
      m_bin  = '0;
      m_err  = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
        bad = has_bad(bcd);
`endif
        if (bad) begin
          m_left     = 1;
          m_pend_bin = '0;
          m_pend_err = 1'b1;
        end else begin
          m_left     = LAT;
          m_pend_bin = W'(dec_value(bcd));
          m_pend_err = 1'b0;
        end
      end
    end else begin
      m_left--;
    end
    if (!rst && m_left == 1) begin
      m_bin = m_pend_bin;
      m_err = m_pend_err;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_left == 1));
      check("bin", 32'(bin), 32'(m_bin));
      check("err", 32'(err), 32'(m_err));
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) timeout("wait_idle");
  endtask

  task automatic convert(input logic [W-1:0] v, input int exp_lat,
                         input logic [W-1:0] exp_bin, input logic exp_err,
                         input string name);
    int k;
    wait_idle();
    bcd   = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      timeout({name, "_done"});
    end else begin
      check({name, "_lat"}, 32'(k), 32'(exp_lat));
      check({name, "_busy"}, 32'(busy), 32'd1);
      check({name, "_bin"}, 32'(bin), 32'(exp_bin));
      check({name, "_err"}, 32'(err), 32'(exp_err));
    end
  endtask

  initial begin
    int ndone;
    int last_t;
    logic [W-1:0] seen_bin;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    check("model_dec407", 32'(dec_value(12'h407)), 32'd407);
    check("model_dec999", 32'(dec_value(12'h999)), 32'd999);

    convert(12'h999, LAT, 12'h3E7, 1'b0, "c999");
    convert(12'h000, LAT, 12'h000, 1'b0, "c000");
    convert(12'h407, LAT, 12'h197, 1'b0, "c407");
    convert(12'h010, LAT, 12'h00A, 1'b0, "c010");

    // A start during SHIFT must be ignored.
    wait_idle();
    bcd = 12'h250;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bcd = 12'h111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    seen_bin = '0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        seen_bin = bin;
      end
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_bin", 32'(seen_bin), 32'h0FA);

    // Reset in the middle of a conversion.
    wait_idle();
    bcd = 12'h999;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bin", 32'(bin), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    convert(12'h123, LAT, 12'h07B, 1'b0, "c123");

`ifdef BCD_DIGIT_CHECK_EN
    convert(12'h9A1, 1, 12'h000, 1'b1, "bad9A1");
    convert(12'h005, LAT, 12'h005, 1'b0, "after_bad");
`endif

    // start held high: a new acceptance every LAT+1 cycles.
    wait_idle();
    start = 1'b1;
    ndone = 0;
    last_t = -1;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      bcd = rand_bcd();
      if (done === 1'b1) begin
        ndone++;
        if (last_t >= 0) check("b2b_gap", 32'(t - last_t), 32'(LAT + 1));
        last_t = t;
      end
    end
    start = 1'b0;
    check("b2b_ndone", 32'(ndone), 32'd5);

    // Randomized traffic, checked every cycle against the model.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      bcd   = rand_bcd();
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
